// File: rtl/rvfi_tohost_monitor.sv
// RVFI tohost monitor: ends the test on an exit store or cycle timeout.
// Optional syscall FIFO is built when RVFI_TOHOST_MON_SYSCALL_EN is defined.
module rvfi_tohost_monitor #(
  parameter int NR_PORTS = 2,
  parameter int XLEN     = 64,
  parameter int PLEN     = 56,
  parameter int CNT_W    = 32,
  parameter int SC_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NR_PORTS-1:0]      commit_valid_i,
  input  logic [NR_PORTS-1:0]      commit_store_i,
  input  logic [NR_PORTS*PLEN-1:0] commit_paddr_i,
  input  logic [NR_PORTS*XLEN-1:0] commit_wdata_i,
  input  logic [PLEN-1:0]          tohost_addr_i,
  input  logic [CNT_W-1:0]         timeout_i,
  output logic                     done_o,
  output logic [31:0]              end_of_test_o,
  output logic [CNT_W-1:0]         cycles_o,
  output logic                     sc_valid_o,
  output logic [XLEN-1:0]          sc_data_o,
  input  logic                     sc_ready_i,
  output logic                     sc_overflow_o
);

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  state_t              r_state, w_state_next;
  logic                r_done, w_done_next;
  logic [31:0]         r_eot, w_eot_next;
  logic [CNT_W-1:0]    r_cycles, w_cycles_next;
  logic [NR_PORTS-1:0] w_hit;
  logic [NR_PORTS-1:0] w_sc_req;
  logic                w_exit;
  logic [31:0]         w_exit_code;
  logic                w_timeout;

  always_comb begin
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      w_hit[i] = commit_valid_i[i] && commit_store_i[i] && (tohost_addr_i != '0) &&
                 (commit_paddr_i[i*PLEN +: PLEN] == tohost_addr_i);
    end
  end

  // Ascending scan: the first exit masks every higher-index port this cycle.
  always_comb begin
    w_exit      = 1'b0;
    w_exit_code = '0;
    w_sc_req    = '0;
    if (r_state == S_RUN) begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        if (w_hit[i] && !w_exit) begin
          if (commit_wdata_i[i*XLEN]) begin
            w_exit      = 1'b1;
            w_exit_code = commit_wdata_i[i*XLEN +: 32];
          end else begin
            w_sc_req[i] = 1'b1;
          end
        end
      end
    end
  end

  assign w_timeout = (timeout_i != '0) && (r_cycles == timeout_i - CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_RUN;
      r_done   <= 1'b0;
      r_eot    <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_next;
      r_done   <= w_done_next;
      r_eot    <= w_eot_next;
      r_cycles <= w_cycles_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_done_next   = r_done;
    w_eot_next    = r_eot;
    w_cycles_next = r_cycles;
    case (r_state)
      S_RUN: begin
        if (r_cycles != '1) w_cycles_next = r_cycles + CNT_W'(1);
        if (w_exit) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
          w_eot_next   = w_exit_code;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
          w_eot_next   = '1;
        end
      end
      default: ;
    endcase
  end

  assign done_o        = r_done;
  assign end_of_test_o = r_eot;
  assign cycles_o      = r_cycles;

`ifdef RVFI_TOHOST_MON_SYSCALL_EN
  localparam int AW = $clog2(SC_DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0]     r_mem [SC_DEPTH];
  logic [PW-1:0]       r_wr, r_rd;
  logic                r_sc_valid, r_ovf;
  logic [XLEN-1:0]     r_sc_data;
  logic [PW-1:0]       w_count, w_free, w_n_push, w_wr_next, w_rd_next;
  logic                w_pop, w_drop, w_valid_next;
  logic [NR_PORTS-1:0] w_push;
  logic [AW-1:0]       w_slot [NR_PORTS];
  logic [XLEN-1:0]     w_data_next;

  // Free space includes the slot released by a same-cycle pop.
  always_comb begin
    w_count  = r_wr - r_rd;
    w_pop    = r_sc_valid && sc_ready_i;
    w_free   = PW'(SC_DEPTH) - w_count + PW'(w_pop);
    w_n_push = '0;
    w_push   = '0;
    w_drop   = 1'b0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      w_slot[i] = r_wr[AW-1:0] + w_n_push[AW-1:0];
      if (w_sc_req[i]) begin
        if (w_n_push < w_free) begin
          w_push[i] = 1'b1;
          w_n_push  = w_n_push + PW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    w_wr_next    = r_wr + w_n_push;
    w_rd_next    = r_rd + PW'(w_pop);
    w_valid_next = (w_wr_next != w_rd_next);
    w_data_next  = r_mem[w_rd_next[AW-1:0]];
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (w_push[i] && (w_slot[i] == w_rd_next[AW-1:0])) begin
        w_data_next = commit_wdata_i[i*XLEN +: XLEN];
      end
    end
    if (!w_valid_next) w_data_next = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_sc_valid <= 1'b0;
      r_sc_data  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_wr       <= w_wr_next;
      r_rd       <= w_rd_next;
      r_sc_valid <= w_valid_next;
      r_sc_data  <= w_data_next;
      r_ovf      <= r_ovf | w_drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        if (w_push[i]) r_mem[w_slot[i]] <= commit_wdata_i[i*XLEN +: XLEN];
      end
    end
  end

  assign sc_valid_o    = r_sc_valid;
  assign sc_data_o     = r_sc_data;
  assign sc_overflow_o = r_ovf;
`else
  logic [NR_PORTS*XLEN+NR_PORTS:0] w_unused;
  assign w_unused      = {sc_ready_i, w_sc_req, commit_wdata_i};
  assign sc_valid_o    = 1'b0;
  assign sc_data_o     = '0;
  assign sc_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_tohost_monitor.sv
// Directed bench for rvfi_tohost_monitor: vector table plus multi-cycle sequences.
// FIFO sequences follow RVFI_TOHOST_MON_SYSCALL_EN; otherwise the tied-off outputs are checked.
module tb_rvfi_tohost_monitor;
  localparam int NP = 2;
  localparam int XL = 64;
  localparam int PL = 56;
  localparam int CW = 32;
  localparam int D  = 4;
  localparam logic [55:0] TH = 56'h8000_1000;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     cv, cs;
  logic [111:0]   pa;
  logic [127:0]   wd;
  logic [55:0]    th;
  logic [31:0]    to;
  logic           done;
  logic [31:0]    eot;
  logic [31:0]    cyc;
  logic           scv;
  logic [63:0]    scd;
  logic           rdy;
  logic           ovf;
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  rvfi_tohost_monitor #(.NR_PORTS(NP), .XLEN(XL), .PLEN(PL), .CNT_W(CW), .SC_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_store_i(cs),
    .commit_paddr_i(pa), .commit_wdata_i(wd), .tohost_addr_i(th), .timeout_i(to),
    .done_o(done), .end_of_test_o(eot), .cycles_o(cyc), .sc_valid_o(scv),
    .sc_data_o(scd), .sc_ready_i(rdy), .sc_overflow_o(ovf)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  v, s;
    logic [55:0] a0, a1;
    logic [63:0] d0, d1;
    logic        e_done;
    logic [31:0] e_eot;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] s,
                              input logic [55:0] a0, input logic [55:0] a1,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic ed, input logic [31:0] ee, input logic [31:0] ec);
    vec_t t;
    t.rst = r; t.v = v; t.s = s; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.e_done = ed; t.e_eot = ee; t.e_cyc = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [1:0] v, input logic [1:0] s, input logic [55:0] a0,
                     input logic [55:0] a1, input logic [63:0] d0, input logic [63:0] d1);
    cv = v; cs = s; pa = {a1, a0}; wd = {d1, d0};
  endtask

  task automatic idle();
    cv = '0; cs = '0; pa = '0; wd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_main(input string name, input logic ed, input logic [31:0] ee,
                          input logic [31:0] ec);
    chk({name, ".done"}, 64'(done), 64'(ed));
    chk({name, ".eot"}, 64'(eot), 64'(ee));
    chk({name, ".cyc"}, 64'(cyc), 64'(ec));
  endtask

  task automatic chk_sc(input string name, input logic ev, input logic [63:0] ed);
    chk({name, ".scv"}, 64'(scv), 64'(ev));
    if (ev) chk({name, ".scd"}, scd, ed);
  endtask

  initial begin
    rst = 1'b1; idle(); th = TH; to = '0; rdy = 1'b0;

    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'(k + 1)));
    tbl.push_back(mk(0, 2'b11, 2'b11, 56'h8000_2000, TH, 64'h1, 64'h1, 1, 32'h1, 11));
    tbl.push_back(mk(0, 2'b01, 2'b01, TH, 0, 64'h5, 0, 1, 32'h1, 11));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h1, 11));
    tbl.push_back(mk(1, 2'b01, 2'b01, TH, 0, 64'h7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, TH, TH, 64'h1, 64'h1, 0, 0, 1));
    tbl.push_back(mk(0, 2'b11, 2'b11, TH, TH, 64'h2B, 64'h11, 1, 32'h2B, 2));
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, TH, 0, 64'h10, 0, 0, 0, 1));
    tbl.push_back(mk(0, 2'b01, 2'b01, TH, 0, 64'hDEAD_BEEF_0000_0003, 0, 1, 32'h3, 2));

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      drv(tbl[i].v, tbl[i].s, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      tick();
      chk_main($sformatf("tbl%0d", i), tbl[i].e_done, tbl[i].e_eot, tbl[i].e_cyc);
    end
    idle(); rst = 1'b0;

    // timeout of 100 with no stores
    to = 32'd100;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c == 98) chk_main("to_early", 1'b0, 32'h0, 32'd99);
    end
    chk_main("to_fire", 1'b1, 32'hFFFF_FFFF, 32'd100);
    tick(); tick();
    chk("to_frozen.cyc", 64'(cyc), 64'd100);

    // exit in the last cycle before timeout wins
    do_reset();
    for (int c = 0; c < 99; c++) tick();
    drv(2'b01, 2'b01, TH, 0, 64'h9, 0);
    tick();
    idle();
    chk_main("exit99", 1'b1, 32'h9, 32'd100);

    // tohost address 0 disables detection
    th = '0; to = 32'd20;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      drv(2'b11, 2'b11, 0, TH, 64'h1, 64'h1);
      tick();
    end
    chk_main("th0_run", 1'b0, 32'h0, 32'd19);
    tick();
    idle();
    chk_main("th0_to", 1'b1, 32'hFFFF_FFFF, 32'd20);
    th = TH;

    // smallest timeout
    to = 32'd1;
    do_reset();
    tick();
    chk_main("to1", 1'b1, 32'hFFFF_FFFF, 32'd1);
    to = '0;

`ifdef RVFI_TOHOST_MON_SYSCALL_EN
    // five syscalls into a depth-4 FIFO with no consumer
    rdy = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drv(2'b01, 2'b01, TH, 0, 64'(16 * (k + 1)), 0);
      tick();
      if (k == 0) chk_sc("ovf_first", 1'b1, 64'h10);
      if (k == 3) chk("ovf_at4.ovf", 64'(ovf), 64'd0);
    end
    idle();
    chk("ovf_at5.ovf", 64'(ovf), 64'd1);
    chk_sc("ovf_head", 1'b1, 64'h10);
    rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_sc($sformatf("drain%0d", j), 1'b1, 64'(16 * (j + 2)));
    end
    tick();
    chk_sc("drain_empty", 1'b0, 64'h0);
    chk("drain_ovf_sticky", 64'(ovf), 64'd1);
    rdy = 1'b0;

    // syscall below exit is pushed; reset from DONE with FIFO occupied
    do_reset();
    drv(2'b11, 2'b11, TH, TH, 64'h100, 64'h3);
    tick();
    chk_main("sc_exit", 1'b1, 32'h3, 32'd1);
    chk_sc("sc_exit", 1'b1, 64'h100);
    do_reset();
    chk_main("rst_done", 1'b0, 32'h0, 32'h0);
    chk_sc("rst_done", 1'b0, 64'h0);
    chk("rst_done.scd", scd, 64'h0);
    chk("rst_done.ovf", 64'(ovf), 64'd0);
    drv(2'b10, 2'b10, 0, TH, 0, 64'h7);
    tick();
    idle();
    chk_main("rst_exit", 1'b1, 32'h7, 32'd1);
    chk_sc("rst_exit", 1'b0, 64'h0);

    // exit on port 0 masks port 1; DONE ignores further syscalls
    do_reset();
    drv(2'b11, 2'b11, TH, TH, 64'h3, 64'h200);
    tick();
    chk_main("rev", 1'b1, 32'h3, 32'd1);
    chk_sc("rev", 1'b0, 64'h0);
    drv(2'b01, 2'b01, TH, 0, 64'h300, 0);
    tick();
    idle();
    chk_sc("done_sc", 1'b0, 64'h0);

    // full FIFO: pop plus two pushes admits exactly one
    do_reset();
    drv(2'b11, 2'b11, TH, TH, 64'hA0, 64'hA1);
    tick();
    drv(2'b11, 2'b11, TH, TH, 64'hA2, 64'hA3);
    tick();
    chk("full.ovf", 64'(ovf), 64'd0);
    chk_sc("full", 1'b1, 64'hA0);
    rdy = 1'b1;
    drv(2'b11, 2'b11, TH, TH, 64'hB0, 64'hB1);
    tick();
    idle();
    chk("pp.ovf", 64'(ovf), 64'd1);
    chk_sc("pp", 1'b1, 64'hA1);
    tick(); chk_sc("pp_a2", 1'b1, 64'hA2);
    tick(); chk_sc("pp_a3", 1'b1, 64'hA3);
    tick(); chk_sc("pp_b0", 1'b1, 64'hB0);
    tick(); chk_sc("pp_empty", 1'b0, 64'h0);
    rdy = 1'b0;
`else
    // syscall stores leave the tied-off FIFO outputs at zero
    rdy = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drv(2'b11, 2'b11, TH, TH, 64'(32 * k + 16), 64'(32 * k + 32));
      tick();
      chk($sformatf("nosc%0d.scv", k), 64'(scv), 64'd0);
      chk($sformatf("nosc%0d.scd", k), scd, 64'd0);
      chk($sformatf("nosc%0d.ovf", k), 64'(ovf), 64'd0);
    end
    chk_main("nosc_run", 1'b0, 32'h0, 32'd5);
    rdy = 1'b1;
    drv(2'b11, 2'b11, TH, TH, 64'h100, 64'h3);
    tick();
    idle();
    chk_main("nosc_exit", 1'b1, 32'h3, 32'd6);
    chk("nosc_exit.scv", 64'(scv), 64'd0);
    rdy = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rvfi_tohost_monitor.md
# rvfi_tohost_monitor

Synthesizable, parametrised end-of-test and syscall monitor for the RVFI commit stream. It scans every commit port each cycle for stores to the `tohost` physical address. It terminates the test on an exit code or on a cycle timeout, and queues non-exit `tohost` writes as syscall requests behind a valid/ready FIFO. It sits beside the core in the testbench/FPGA harness and replaces DPI-based termination, so it works in emulation.

## Interface
- `NR_PORTS`, default 2: commit ports scanned, range 1..4.
- `XLEN`, default 64: store data width.
- `PLEN`, default 56: physical address width.
- `CNT_W`, default 32: cycle counter width.
- `SC_DEPTH`, default 4: syscall FIFO depth, power of two ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `commit_valid_i` in NR_PORTS: per-port committed-instruction valid.
- `commit_store_i` in NR_PORTS: per-port store flag (mem_wmask != 0).
- `commit_paddr_i` in NR_PORTS*PLEN: per-port store physical address; port i at [i*PLEN +: PLEN].
- `commit_wdata_i` in NR_PORTS*XLEN: per-port store data.
- `tohost_addr_i` in PLEN: tohost address, quasi-static; 0 disables detection.
- `timeout_i` in CNT_W: cycle limit, quasi-static; 0 disables timeout.
- `done_o` out 1: test finished, sticky.
- `end_of_test_o` out 32: exit code (tohost wdata[31:0]) or 32'hFFFF_FFFF on timeout.
- `cycles_o` out CNT_W: cycles elapsed in RUN.
- `sc_valid_o` out 1: syscall FIFO head valid.
- `sc_data_o` out XLEN: syscall FIFO head data.
- `sc_ready_i` in 1: consumer accepts head.
- `sc_overflow_o` out 1: sticky, a syscall was dropped because the FIFO was full.

## Operation
- Port i is a hit when commit_valid_i[i], commit_store_i[i], tohost_addr_i != 0, and paddr == tohost_addr_i all hold.
- FSM has two states:
  - RUN: the reset state.
  - DONE: entered on an exit hit or a timeout. Leaves only on reset.
- In RUN, ports are scanned in ascending index order each cycle:
  - Hit with wdata[0]=1 is an exit. Latch wdata[31:0] into end_of_test_o and go to DONE. Ignore all higher-index ports that cycle.
  - Hit with wdata[0]=0 is a syscall. Push wdata in port order, but only for ports below any exit port that cycle.
- Multiple pushes per cycle are allowed, up to NR_PORTS.
  - Pushes beyond free space are dropped.
  - Free space counts the same-cycle pop.
  - Any drop sets sc_overflow_o.
- Timeout: when timeout_i != 0 and cycles_o == timeout_i - 1 in RUN with no exit hit, latch 32'hFFFF_FFFF and go to DONE.
- In DONE:
  - No further hits are processed and cycles_o freezes.
  - The FIFO keeps draining through sc_valid_o/sc_ready_i.
- cycles_o increments by 1 every RUN cycle and saturates at all-ones.
- FIFO ordering: first-in first-out; lower port index first within a cycle.

## Timing
- All outputs are registered.
- Reset values: done_o=0, end_of_test_o=0, cycles_o=0, sc_valid_o=0, sc_data_o=0, sc_overflow_o=0, FIFO empty, state RUN.
- Exit hit in cycle N: done_o and end_of_test_o valid from N+1.
- Syscall push in cycle N: sc_valid_o=1 from N+1 if the FIFO was empty. No fall-through.
- Pop occurs in a cycle where sc_valid_o && sc_ready_i; the next head appears at N+1.
- A simultaneous push and pop on a full FIFO admits one push.
- Timeout: done_o rises exactly timeout_i cycles after reset deassertion.
- An exit hit and timeout in the same cycle: the exit wins.
- Reset mid-operation clears the FIFO, overflow, counter and FSM in the same edge. Inputs in that cycle are ignored.

## Configuration
- `RVFI_TOHOST_MON_SYSCALL_EN`:
  - Defined: syscall FIFO and sc_* ports are active as above.
  - Undefined:
    - No FIFO is instantiated and wdata[0]=0 hits are ignored.
    - sc_valid_o=0, sc_data_o=0 and sc_overflow_o=0 are tied.
    - sc_ready_i is unused.
    - Exit and timeout behaviour is unchanged.

## Test plan
- tohost=0x8000_1000, timeout 0; port 1 stores 0x1 to tohost at cycle 10 → done_o=1, end_of_test_o=0x1 at cycle 11; cycles_o frozen at 11.
- timeout_i=100, no stores → done_o rises at cycle 100 with end_of_test_o=0xFFFF_FFFF. Exit hit at cycle 99 → end_of_test_o = exit code, not timeout.
- sc_ready_i=0; five syscall stores 0x10,0x20,0x30,0x40,0x50 with SC_DEPTH=4 → FIFO holds 0x10..0x40 and sc_overflow_o=1. After raising ready, sc_data_o pops 0x10,0x20,0x30,0x40 on consecutive cycles.
- Same cycle: port 0 syscall 0x100, port 1 exit 0x3 → FIFO gets 0x100, end_of_test_o=0x3. Reversed ports (port 0 exit) → FIFO stays empty.
- tohost_addr_i=0 with exit-valued stores → no termination until timeout. Build without macro: syscall stores leave sc_valid_o=0.
- Assert rst_i for one cycle while in DONE with FIFO non-empty → all outputs return to reset values next cycle; a later exit is detected normally.
